board_input_regs: RTL
=====================

# board_input_regs

Memory-mapped peripheral that presents the DE1-SoC push-buttons and slide switches to the HPS over the lightweight Avalon-MM bridge. It is the slave end of the HPS-to-fabric bus; the NES emulator software polls it, or takes its interrupt, for menu and controller input. The block synchronizes and debounces the raw inputs, latches sticky change events, and counts key presses. It raises a maskable level interrupt.

## Interface
- DEBOUNCE_CYCLES, 50000, clk cycles per debounce sample tick (1 ms at 50 MHz); must be ≥2.
- clk  in  1  system clock (same domain as the Avalon slave).
- reset  in  1  one clock; reset is synchronous and active-high.
- key_n  in  4  raw push-buttons, active-low, asynchronous.
- sw  in  10  raw slide switches, active-high, asynchronous.
- address  in  2  word address.
- chipselect  in  1  slave select.
- read  in  1  read strobe; valid only with chipselect.
- write  in  1  write strobe; valid only with chipselect.
- writedata  in  32  write data.
- readdata  out  32  read data, registered; fixed read latency 1.
- irq  out  1  level interrupt to the HPS.

## Operation
- Input vector in[13:0] = {sw, ~key_n}. Bit 1 means pressed or on.
- Synchronizer: 2-flop synchronizer per bit, giving s[13:0].
- Tick: a prescaler counts 0..DEBOUNCE_CYCLES-1. tick=1 for one cycle when the count equals DEBOUNCE_CYCLES-1, then the count wraps to 0.
- Debounce: on each tick, every bit shifts s into a 3-deep history h[2:0].
  - Let db be the debounced state. When the new history is all-1 and db=0, db←1; when it is all-0 and db=1, db←0.
  - Otherwise db holds.
- Events: a change in db sets the sticky EDGE bit in the same cycle that db updates.
  - Key bits [3:0] set only on a press (0→1).
  - Switch bits [13:4] set on either transition.
- Press counter CNT[15:0] increments by the number of key bits with a 0→1 db change this cycle (0..4). It wraps modulo 2^16.
- Register map (readdata bits not listed read 0):
  - 0 STATUS, RO: [13:0]=db.
  - 1 EDGE, R/W1C: [13:0] sticky events. Writing 1 to a bit clears it.
  - 2 MASK, RW: [13:0] interrupt enables.
  - 3 CNT, RO: [15:0] press count. Any write clears it.
- Read: when chipselect&read in cycle N, readdata holds the register value as sampled at N, starting in cycle N+1. Otherwise readdata holds its last value. Reads have no side effects.
- irq: registered copy of |(EDGE & MASK).
- Simultaneous events:
  - W1C on an EDGE bit in the same cycle that bit's event fires: the bit stays 1 (set wins).
  - CNT clear coinciding with k presses: CNT←k.
  - Read coinciding with an update: returns the pre-update value.
- Reset values: readdata=0, irq=0, db=0, h=0, EDGE=0, MASK=0, CNT=0, prescaler=0, synchronizer flops=0.
- Reset mid-operation:
  - Everything above returns to its reset value immediately, including any pending debounce history.
  - A switch held on, or a key held pressed, through reset produces an event 3 ticks after reset is released. Software clears EDGE at init.

## Timing
- Input to db latency: 2 cycles of synchronizer, then 3 consecutive ticks that sample the new level. db updates on the cycle after the third such tick.
- Worst case: 2 + 3·DEBOUNCE_CYCLES + 1 cycles.
- EDGE and CNT update in the same cycle as db. irq follows one cycle later.
- Glitch rejection: any pulse shorter than 2·DEBOUNCE_CYCLES is guaranteed rejected, because it cannot span 3 ticks.
- An Avalon access completes with no waitrequest. Back-to-back reads are supported, one per cycle.

## Test plan
- Reset with key_n=4'hF and sw=0, DEBOUNCE_CYCLES=4 → all registers read 0 and irq=0. Then drive key_n[0]=0 → STATUS=0x1, EDGE=0x1, CNT=1 within 15 cycles. Release key_n[0] → STATUS=0, EDGE still 0x1, CNT still 1.
- Drive a glitch on sw[2] of 7 cycles (DEBOUNCE_CYCLES=4) → STATUS, EDGE and CNT unchanged. Hold sw[2] high for 20 cycles → STATUS=0x40 and EDGE=0x40.
- Set MASK=0x2, then press key1 → irq=1 one cycle after EDGE[1] sets. Write EDGE=0x2 → EDGE[1] clears and irq=0 one cycle later. Pressing key0 with MASK=0x2 → irq stays 0.
- Set CNT=0xFFFF via 65535 forced presses, or start from a preloaded state, then press once → CNT=0x0000. Write to address 3 in the same cycle as a simultaneous press of key2 and key3 → CNT=2.
- Issue W1C of EDGE[5] in the same cycle that a sw[1] event fires → EDGE[5] remains 1. A read of EDGE in that cycle returns the pre-event value on readdata in the next cycle.
- Assert reset while sw[9] is held high and a debounce is mid-count → registers read 0 during reset. STATUS=0x2000 and EDGE=0x2000 appear 3 ticks after reset is released.

Source files
------------

// File: rtl/board_input_regs_if.sv
// Avalon-MM slave bus between the lightweight HPS bridge and the board input registers.
// Single-cycle accesses with no waitrequest; readdata is valid the cycle after a read.
interface board_input_regs_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, read, write, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, read, write, writedata,
        output readdata
    );
endinterface

// File: rtl/board_input_regs.sv
// Debounced DE1-SoC keys/switches behind four Avalon-MM registers, with sticky events, press count and irq.
// readdata one cycle after a read; no backpressure, every access accepted; irq lags EDGE by one cycle.
module board_input_regs #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        key_n,
    input  logic [9:0]        sw,
    board_input_regs_if.slave bus,
    output logic              irq
);
    localparam int NB = 14;
    localparam int PW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [PW-1:0] PRE_LAST = PW'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] ADDR_STATUS = 2'd0;
    localparam logic [1:0] ADDR_EDGE   = 2'd1;
    localparam logic [1:0] ADDR_MASK   = 2'd2;
    localparam logic [1:0] ADDR_CNT    = 2'd3;

    logic [NB-1:0]      raw_in;
    logic [NB-1:0]      sync1_q;
    logic [NB-1:0]      sync2_q;
    logic [PW-1:0]      pre_q;
    logic               tick;
    logic [NB-1:0][2:0] hist_q;
    logic [NB-1:0][2:0] hist_nxt;
    logic [NB-1:0]      db_q;
    logic [NB-1:0]      db_nxt;
    logic [NB-1:0]      rise;
    logic [NB-1:0]      fall;
    logic [NB-1:0]      event_set;
    logic [NB-1:0]      w1c_bits;
    logic [NB-1:0]      edge_q;
    logic [NB-1:0]      edge_nxt;
    logic [NB-1:0]      mask_q;
    logic [15:0]        cnt_q;
    logic [15:0]        cnt_nxt;
    logic [2:0]         press_inc;
    logic [31:0]        rd_mux;
    logic [31:0]        rd_q;
    logic               irq_q;
    logic               rd_en;
    logic               wr_en;
    logic               wr_edge;
    logic               wr_mask;
    logic               wr_cnt;
    logic               unused_wdata;

    // Keys are inverted so every bit reads 1 when pressed or switched on.
    assign raw_in = {sw, ~key_n};

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= raw_in;
            sync2_q <= sync1_q;
        end
    end

    assign tick = (pre_q == PRE_LAST);

    always_ff @(posedge clk) begin
        if (reset || tick) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_q + PW'(1);
        end
    end

    // A bit only flips once three consecutive tick samples agree on the new level.
    always_comb begin
        hist_nxt = hist_q;
        db_nxt   = db_q;
        if (tick) begin
            for (int b = 0; b < NB; b++) begin
                hist_nxt[b] = {hist_q[b][1:0], sync2_q[b]};
                if (&hist_nxt[b]) begin
                    db_nxt[b] = 1'b1;
                end else if (~|hist_nxt[b]) begin
                    db_nxt[b] = 1'b0;
                end
            end
        end
    end

    assign rise      = db_nxt & ~db_q;
    assign fall      = db_q & ~db_nxt;
    assign event_set = {rise[NB-1:4] | fall[NB-1:4], rise[3:0]};
    assign press_inc = 3'(rise[0]) + 3'(rise[1]) + 3'(rise[2]) + 3'(rise[3]);

    assign rd_en   = bus.chipselect & bus.read;
    assign wr_en   = bus.chipselect & bus.write;
    assign wr_edge = wr_en && (bus.address == ADDR_EDGE);
    assign wr_mask = wr_en && (bus.address == ADDR_MASK);
    assign wr_cnt  = wr_en && (bus.address == ADDR_CNT);

    // New events are OR-ed in after the clear so a coincident event survives W1C.
    assign w1c_bits = wr_edge ? bus.writedata[NB-1:0] : {NB{1'b0}};
    assign edge_nxt = (edge_q & ~w1c_bits) | event_set;
    assign cnt_nxt  = wr_cnt ? {13'd0, press_inc} : cnt_q + {13'd0, press_inc};

    assign unused_wdata = ^bus.writedata[31:NB];

    always_comb begin
        rd_mux = 32'd0;
        case (bus.address)
            ADDR_STATUS: rd_mux = {{(32-NB){1'b0}}, db_q};
            ADDR_EDGE:   rd_mux = {{(32-NB){1'b0}}, edge_q};
            ADDR_MASK:   rd_mux = {{(32-NB){1'b0}}, mask_q};
            ADDR_CNT:    rd_mux = {16'd0, cnt_q};
            default:     rd_mux = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hist_q <= '0;
            db_q   <= '0;
            edge_q <= '0;
            mask_q <= '0;
            cnt_q  <= '0;
            rd_q   <= '0;
            irq_q  <= 1'b0;
        end else begin
            hist_q <= hist_nxt;
            db_q   <= db_nxt;
            edge_q <= edge_nxt;
            cnt_q  <= cnt_nxt;
            irq_q  <= |(edge_q & mask_q);
            if (wr_mask) begin
                mask_q <= bus.writedata[NB-1:0];
            end
            if (rd_en) begin
                rd_q <= rd_mux;
            end
        end
    end

    assign bus.readdata = rd_q;
    assign irq          = irq_q;
endmodule
